// File: rtl/mem_sweep_ctrl.sv
// mem_sweep_ctrl: drives a no-write-enable block RAM for full-depth checksum reads and seeded fills
module mem_sweep_ctrl #(
    parameter int WID_MEM   = 8,
    parameter int DEPTH_MEM = 2048,
    parameter int PARK_ADDR = DEPTH_MEM
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [WID_MEM-1:0] seed,
    output logic               busy,
    output logic               done,
    output logic [31:0]        checksum,
    output logic [31:0]        raddr,
    output logic [31:0]        waddr,
    output logic [WID_MEM-1:0] din,
    input  logic [WID_MEM-1:0] dout
);
    localparam int AW = $clog2(DEPTH_MEM);
    typedef enum logic [2:0] {IDLE, RD, RD_TAIL, FILL, DONE} state_t;
    state_t state;
    logic [AW-1:0] cnt, raddr_q;
    logic [WID_MEM-1:0] seed_q;
    logic wb_valid;
    logic [31:0] acc;
    assign raddr = 32'(cnt);
    assign acc = {checksum[30:0], checksum[31]} ^ 32'(dout);
    // The RAM writes every clock, so waddr/din are always driven: fill data, a write-back of the word read last cycle, or the park address
    always_comb begin
        waddr = !reset ? 32'(PARK_ADDR) : state == FILL ? 32'(cnt) : wb_valid ? 32'(raddr_q) : 32'(PARK_ADDR);
        din   = state == FILL ? seed_q + WID_MEM'(cnt) : dout;
    end
    // Sweep sequencer; cnt doubles as the read address so raddr tracks it in every state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            checksum <= '0;
            cnt      <= '0;
            raddr_q  <= '0;
            seed_q   <= '0;
            wb_valid <= 1'b0;
        end else begin
            raddr_q  <= cnt;
            wb_valid <= state != FILL;
            done     <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cnt    <= '0;
                    busy   <= 1'b1;
                    seed_q <= seed;
                    state  <= mode ? FILL : RD;
                    if (!mode) checksum <= '0;
                end
                RD: begin
                    if (cnt != '0) checksum <= acc;
                    if (&cnt) state <= RD_TAIL;
                    else cnt <= cnt + 1'b1;
                end
                RD_TAIL: begin
                    checksum <= acc;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                FILL: if (&cnt) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end else cnt <= cnt + 1'b1;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// tb_mem_sweep_ctrl: randomized sweeps against a behavioural RAM and checksum model
module tb_mem_sweep_ctrl;
    localparam int D = 2048;
    logic clk = 0, reset = 0, start = 0, mode = 0, start4 = 0;
    logic [7:0] seed = 0;
    logic busy, done, busy4, done4;
    logic [31:0] checksum, raddr, waddr, checksum4, raddr4, waddr4;
    logic [7:0] din, dout, din4, dout4;
    logic [7:0] ram [0:D];
    logic [7:0] ram4 [0:4];
    logic [7:0] ref_mem [0:D-1];
    int checks = 0, passed = 0, park_err = 0, range_err = 0;
    int cyc, pulses;
    logic [31:0] sum1;
    logic [7:0] s;

    mem_sweep_ctrl #(.WID_MEM(8), .DEPTH_MEM(D)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .busy(busy), .done(done), .checksum(checksum), .raddr(raddr),
        .waddr(waddr), .din(din), .dout(dout));

    mem_sweep_ctrl #(.WID_MEM(8), .DEPTH_MEM(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .mode(1'b0), .seed(8'h00),
        .busy(busy4), .done(done4), .checksum(checksum4), .raddr(raddr4),
        .waddr(waddr4), .din(din4), .dout(dout4));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dout <= ram[raddr[11:0]];
        ram[waddr[11:0]] <= din;
        dout4 <= ram4[raddr4[2:0]];
        ram4[waddr4[2:0]] <= din4;
    end

    always @(negedge clk) begin
        if (!reset && waddr != D) park_err++;
        if (waddr > D || waddr4 > 4) range_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_sum();
        logic [31:0] c = 0;
        for (int i = 0; i < D; i++) c = ((c << 1) | (c >> 31)) ^ {24'h0, ref_mem[i]};
        return c;
    endfunction

    task automatic mem_cmp(input string tag);
        int bad = 0;
        for (int i = 0; i < D; i++) if (ram[i] !== ref_mem[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic fill_ref(input logic [7:0] sd, input int upto);
        for (int i = 0; i < upto; i++) ref_mem[i] = sd + 8'(i);
    endtask

    task automatic sweep(input logic m, input logic [7:0] sd, input bit hold, output int c, output int p);
        @(posedge clk); #1 start = 1; mode = m; seed = sd;
        @(posedge clk); #1;
        check("busy_first", busy, 1);
        if (!hold) start = 0;
        c = 1;
        p = 0;
        while (!done && c < 3000) begin
            if (hold) begin mode = 1'($urandom); seed = 8'($urandom); end
            @(posedge clk); #1;
            c++;
        end
        if (done) p = 1;
        start = 0;
        mode = 0;
        check("busy_at_done", busy, 0);
        repeat (4) begin @(posedge clk); #1; if (done) p++; end
        check("busy_after", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin ram[i] = 8'(i); ref_mem[i] = 8'(i); end
        for (int i = 0; i < 4; i++) ram4[i] = 8'(i + 1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_checksum", checksum, 0);
        check("rst_raddr", raddr, 0);
        check("rst_waddr", waddr, D);
        reset = 1;
        check("release_park", waddr, D);

        sweep(0, 8'h00, 0, cyc, pulses);
        check("t1_cycles", cyc, D + 2);
        check("t1_pulses", pulses, 1);
        sum1 = model_sum();
        check("t1_checksum", checksum, sum1);
        mem_cmp("t1_mem");

        sweep(1, 8'h5a, 0, cyc, pulses);
        check("t2_cycles", cyc, D + 1);
        check("t2_pulses", pulses, 1);
        check("t2_checksum_held", checksum, sum1);
        fill_ref(8'h5a, D);
        mem_cmp("t2_mem");
        check("t2_last_word", {24'h0, ram[D-1]}, 32'h59);
        sweep(0, 8'h00, 0, cyc, pulses);
        check("t2_checksum", checksum, model_sum());
        mem_cmp("t2_mem_after_read");

        for (int k = 0; k < 2; k++) begin
            s = 8'($urandom);
            sweep(1, s, 0, cyc, pulses);
            fill_ref(s, D);
            mem_cmp("rand_fill_mem");
            sweep(0, 8'($urandom), 0, cyc, pulses);
            check("rand_checksum", checksum, model_sum());
        end

        @(posedge clk); #1 start4 = 1;
        @(posedge clk); #1 start4 = 0;
        cyc = 1;
        while (!done4 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check("t3_cycles", cyc, 6);
        check("t3_checksum", checksum4, 32'h2);
        pulses = done4 ? 1 : 0;
        repeat (3) begin @(posedge clk); #1; if (done4) pulses++; end
        check("t3_pulses", pulses, 1);
        check("t3_busy", busy4, 0);
        check("t3_mem", {ram4[0], ram4[1], ram4[2], ram4[3]}, 32'h01020304);

        sweep(1, 8'h00, 0, cyc, pulses);
        fill_ref(8'h00, D);
        sweep(0, 8'h00, 1, cyc, pulses);
        check("t4_pulses", pulses, 1);
        check("t4_checksum", checksum, sum1);
        mem_cmp("t4_mem");

        @(posedge clk); #1 start = 1; mode = 0;
        @(posedge clk); #1 start = 0;
        cyc = 0;
        while (raddr != 1000 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        check("t5_reached", raddr, 1000);
        reset = 0;
        @(posedge clk); #1;
        check("t5_busy", busy, 0);
        check("t5_checksum", checksum, 0);
        check("t5_park", waddr, D);
        repeat (2) @(posedge clk);
        #1 reset = 1;
        check("t5_release_park", waddr, D);
        repeat (2) @(posedge clk);
        #1;
        check("t5_busy_after", busy, 0);
        mem_cmp("t5_mem");

        s = 8'($urandom);
        @(posedge clk); #1 start = 1; mode = 1; seed = s;
        @(posedge clk); #1 start = 0; mode = 0;
        cyc = 0;
        while (raddr != 500 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        check("t6_reached", raddr, 500);
        reset = 0;
        repeat (3) begin @(posedge clk); #1; check("t6_park", waddr, D); end
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        fill_ref(s, 500);
        mem_cmp("t6_mem");
        check("t6_busy", busy, 0);

        check("park_monitor", park_err, 0);
        check("range_monitor", range_err, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
